// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver: captures one byte per rx_done rising edge,
// pops on rd_en, drops bytes while full and latches a sticky overrun flag.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_prev_q, rx_done_prev_d;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    push_req = rx_done & ~rx_done_prev_q;
    pop      = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  always_comb begin
    rx_done_prev_d = rx_done;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    overrun_d      = overrun_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set wins over clear when a drop coincides with ovr_clr.
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overrun_q      <= 1'b0;
      rx_done_prev_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overrun_q      <= overrun_d;
      rx_done_prev_q <= rx_done_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rx_data;
  end

  always_comb begin
    rd_data = empty ? '0 : mem[rd_ptr_q];
    count   = count_q;
    overrun = overrun_q;
  end

endmodule
